obi_sram_responder: RTL and testbench

// OBI responder (subordinate) end of the core's instruction/data memory interface: req/gnt address phase, rvalid response phase.

---
 rtl/obi_sram_responder.sv | 117 +++++++++++
 tb/tb_obi_sram_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_responder.sv
// OBI responder backed by a byte-enable SRAM. Address phase is req/gnt and the response phase is rvalid.
// Responses leave through a fixed-latency pipeline and return in acceptance order.

module obi_sram_lane #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wbyte,
    output logic [7:0]    rbyte
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wbyte;
    end

    assign rbyte = mem[idx];
endmodule

module obi_sram_responder #(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0220_0000,
    parameter int          READ_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int STAGES = READ_LATENCY - 1;
    localparam int CW     = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [STAGES:0]      vld_pipe;
    rsp_t [STAGES:0]      rsp_pipe;
    logic [CW-1:0]        outs_cnt;
    logic [31:0]          offset;
    logic [AW-1:0]        idx;
    logic                 hit;
    logic                 accept;
    logic                 retire;
    logic [3:0][7:0]      rd_word;
    rsp_t                 rsp_in;

    // Subtract-then-compare handles addresses below BASE_ADDR by wrapping them out of range.
    assign offset = addr_i - BASE_ADDR;
    assign hit    = offset < 32'(4 * DEPTH_WORDS);
    assign idx    = offset[AW+1:2];

    assign retire = vld_pipe[STAGES];
    assign gnt_o  = !rst_i && !stall_i && ((outs_cnt < CW'(MAX_OUTSTANDING)) || retire);
    assign accept = req_i && gnt_o;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        obi_sram_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
            .clk_i (clk_i),
            .we    (accept && we_i && hit && be_i[g]),
            .idx   (idx),
            .wbyte (wdata_i[8*g +: 8]),
            .rbyte (rd_word[g])
        );
    end

    always_comb begin
        rsp_in.err  = !hit;
        rsp_in.data = (hit && !we_i) ? rd_word : 32'h0;
    end

    // Empty stages carry zeros, so the outputs are clean on idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            rsp_pipe <= '0;
            outs_cnt <= '0;
        end else begin
            vld_pipe[0] <= accept;
            rsp_pipe[0] <= accept ? rsp_in : '0;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                rsp_pipe[s] <= rsp_pipe[s-1];
            end
            case ({accept, retire})
                2'b10:   outs_cnt <= outs_cnt + 1'b1;
                2'b01:   outs_cnt <= outs_cnt - 1'b1;
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    assign rvalid_o = vld_pipe[STAGES];
    assign rdata_o  = rsp_pipe[STAGES].data;
    assign err_o    = rsp_pipe[STAGES].err;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (outs_cnt <= CW'(MAX_OUTSTANDING));
            assert (!(retire && outs_cnt == '0));
        end
    end
endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench for obi_sram_responder: four instances with different latency/outstanding settings,
// expected responses queued at grant time and matched (data, err, arrival time) as rvalid appears.
`timescale 1ns/1ps
module tb_obi_sram_responder;
    localparam logic [31:0] BASE = 32'h0220_0000;

    typedef struct {
        logic        err;
        logic [31:0] data;
        longint      t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [4];
    logic        stall [4];
    logic        req   [4];
    logic        gnt   [4];
    logic [31:0] addr  [4];
    logic        we    [4];
    logic [3:0]  be    [4];
    logic [31:0] wdata [4];
    logic        rvalid[4];
    logic [31:0] rdata [4];
    logic        err   [4];

    exp_t exp_q[4][$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   lat[4] = '{1, 2, 3, 3};

    always #5 clk = ~clk;

    obi_sram_responder u0 (
        .clk_i(clk), .rst_i(rst[0]), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
    obi_sram_responder #(.DEPTH_WORDS(16), .READ_LATENCY(2), .MAX_OUTSTANDING(2)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
    obi_sram_responder #(.DEPTH_WORDS(16), .READ_LATENCY(3), .MAX_OUTSTANDING(1)) u2 (
        .clk_i(clk), .rst_i(rst[2]), .stall_i(stall[2]), .req_i(req[2]), .gnt_o(gnt[2]),
        .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]),
        .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));
    obi_sram_responder #(.DEPTH_WORDS(16), .READ_LATENCY(3), .MAX_OUTSTANDING(3)) u3 (
        .clk_i(clk), .rst_i(rst[3]), .stall_i(stall[3]), .req_i(req[3]), .gnt_o(gnt[3]),
        .addr_i(addr[3]), .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]),
        .rvalid_o(rvalid[3]), .rdata_o(rdata[3]), .err_o(err[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one transfer, holds it until granted, and queues the expected response.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic rsp, input logic e_err,
                         input logic [31:0] e_data, output int waits);
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        waits = 0;
        #1;
        while (!gnt[i] && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!gnt[i]) begin
            chk("grant_timeout", {63'd0, gnt[i]}, 64'd1);
            req[i] = 1'b0;
            return;
        end
        if (rsp) exp_q[i].push_back('{e_err, e_data, $time - 1 + lat[i] * 10});
        @(posedge clk);
    endtask

    task automatic idle(input int i);
        @(negedge clk);
        req[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        for (int n = 0; n < 50 && exp_q[i].size() > 0; n++) @(negedge clk);
        chk($sformatf("drain%0d", i), 64'(exp_q[i].size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (rvalid[i]) begin
                    chk($sformatf("rsp_expected%0d", i), {63'd0, exp_q[i].size() > 0}, 64'd1);
                    if (exp_q[i].size() > 0) begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        chk($sformatf("rdata%0d", i), 64'(rdata[i]), 64'(e.data));
                        chk($sformatf("err%0d", i), {63'd0, err[i]}, {63'd0, e.err});
                        chk($sformatf("latency%0d", i), 64'($time), 64'(e.t));
                    end
                end else begin
                    chk($sformatf("idle_clean%0d", i), {31'd0, err[i], rdata[i]}, 64'd0);
                end
            end
        end
    end

    initial begin
        int w;
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; stall[i] = 1'b0; req[i] = 1'b0; addr[i] = '0;
            we[i] = 1'b0; be[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_gnt%0d", i), {63'd0, gnt[i]}, 64'd0);
            chk($sformatf("rst_out%0d", i), {31'd0, rvalid[i], err[i], rdata[i]}, 64'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        mon_en = 1'b1;

        // LAT=1: full write, read-after-write next cycle, partial write, window edges.
        issue(0, 1, BASE, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0, w);
        issue(0, 0, BASE, 4'h0, 32'h0, 1, 0, 32'hDEADBEEF, w);
        issue(0, 1, BASE, 4'b0101, 32'h11223344, 1, 0, 32'h0, w);
        issue(0, 0, BASE, 4'h0, 32'h0, 1, 0, 32'hDE22BE44, w);
        issue(0, 0, BASE + 32'd4096, 4'h0, 32'h0, 1, 1, 32'h0, w);
        issue(0, 1, BASE + 32'd4096, 4'hF, 32'h55555555, 1, 1, 32'h0, w);
        issue(0, 0, BASE - 32'd4, 4'h0, 32'h0, 1, 1, 32'h0, w);
        issue(0, 1, BASE + 32'd4092, 4'hF, 32'hCAFEF00D, 1, 0, 32'h0, w);
        issue(0, 0, BASE + 32'd4093, 4'h0, 32'h0, 1, 0, 32'hCAFEF00D, w);
        issue(0, 0, BASE, 4'h0, 32'h0, 1, 0, 32'hDE22BE44, w);
        issue(0, 1, BASE + 32'd8, 4'h0, 32'hFFFFFFFF, 1, 0, 32'h0, w);
        idle(0);
        stall[0] = 1'b1;
        #1 chk("stall_gnt", {63'd0, gnt[0]}, 64'd0);
        @(negedge clk);
        stall[0] = 1'b0;
        #1 chk("idle_gnt", {63'd0, gnt[0]}, 64'd1);
        drain(0);

        // LAT=2, MAX=2: back-to-back traffic never loses the grant.
        for (int k = 0; k < 8; k++)
            issue(1, 1, BASE + 32'(4 * k), 4'hF, 32'hA500_0000 | 32'(k), 1, 0, 32'h0, w);
        for (int k = 0; k < 8; k++) begin
            issue(1, 0, BASE + 32'(4 * k), 4'h0, 32'h0, 1, 0, 32'hA500_0000 | 32'(k), w);
            chk($sformatf("b2b_wait%0d", k), 64'(w), 64'd0);
        end
        idle(1);
        drain(1);

        // LAT=3, MAX=1: grant only every third cycle, one transfer in flight.
        for (int k = 0; k < 3; k++)
            issue(2, 1, BASE + 32'(4 * k), 4'hF, 32'hB0B0_0000 | 32'(k), 1, 0, 32'h0, w);
        for (int k = 0; k < 3; k++) begin
            issue(2, 0, BASE + 32'(4 * k), 4'h0, 32'h0, 1, 0, 32'hB0B0_0000 | 32'(k), w);
            chk($sformatf("max1_wait%0d", k), 64'(w), 64'd2);
            chk($sformatf("max1_outs%0d", k), {63'd0, exp_q[2].size() <= 1}, 64'd1);
        end
        idle(2);
        drain(2);

        // Reset with two reads in flight: they must never respond; memory survives.
        issue(3, 1, BASE + 32'd20, 4'hF, 32'h12345678, 1, 0, 32'h0, w);
        idle(3);
        drain(3);
        issue(3, 0, BASE + 32'd20, 4'h0, 32'h0, 0, 0, 32'h0, w);
        issue(3, 0, BASE + 32'd20, 4'h0, 32'h0, 0, 0, 32'h0, w);
        @(negedge clk);
        req[3] = 1'b0;
        rst[3] = 1'b1;
        #1 chk("rst_mid_gnt", {63'd0, gnt[3]}, 64'd0);
        @(negedge clk);
        #1 chk("rst_mid_gnt2", {63'd0, gnt[3]}, 64'd0);
        chk("rst_mid_rvalid", {63'd0, rvalid[3]}, 64'd0);
        rst[3] = 1'b0;
        repeat (6) @(negedge clk);
        issue(3, 0, BASE + 32'd20, 4'h0, 32'h0, 1, 0, 32'h12345678, w);
        idle(3);
        drain(3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
